// File: rtl/clk_period_meter_pkg.sv
// Shared types and defaults for the clock period meter and its synchroniser.
// State encoding is fixed so other blocks decoding the meter state agree on it.
package clk_period_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_e;

    localparam int CNT_W_DEF       = 16;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/clk_period_meter_if.sv
// Enable/signal inputs and measurement results of clk_period_meter.
// The stimulus side (master) drives EN_i/SIG_i; the meter (slave) drives the results.
interface clk_period_meter_if
    import clk_period_meter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             EN_i;
    logic             SIG_i;
    logic [CNT_W-1:0] PERIOD_o;
    logic [CNT_W-1:0] HIGH_o;
    logic             VALID_o;
    logic             TIMEOUT_o;

    modport master (
        output EN_i, SIG_i,
        input  PERIOD_o, HIGH_o, VALID_o, TIMEOUT_o
    );

    modport slave (
        input  EN_i, SIG_i,
        output PERIOD_o, HIGH_o, VALID_o, TIMEOUT_o
    );
endinterface

// File: rtl/clk_period_meter_sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous slow clock/data line plus a
// rising-edge detector on the synchronised value.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK_i,
    input  logic RSTn_i,
    input  logic D_i,
    output logic Q_o,
    output logic RISE_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge CLK_i or negedge RSTn_i) begin
        if (!RSTn_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], D_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign Q_o    = sync_q[SYNC_STAGES-1];
    assign RISE_o = Q_o & ~prev_q;
endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow, asynchronous clock in CLK_i cycles.
// Each accepted rising edge closes one period; the first edge after arming only opens one.
module clk_period_meter
    import clk_period_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               CLK_i,
    input  logic               RSTn_i,
    clk_period_meter_if.slave  mif
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic             s, rise;
    logic [CNT_W-1:0] cnt_q, hcnt_q, cnt_d, hcnt_d;
    logic [CNT_W-1:0] period_q, high_q;
    logic             valid_q, timeout_q;
    logic             sat, accept, to_set, to_clr;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .CLK_i  (CLK_i),
        .RSTn_i (RSTn_i),
        .D_i    (mif.SIG_i),
        .Q_o    (s),
        .RISE_o (rise)
    );

    // Saturation is checked before increment, so cnt never wraps.
    assign sat = (cnt_q == CNT_MAX);

    always_ff @(posedge CLK_i or negedge RSTn_i) begin
        if (!RSTn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!mif.EN_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (rise) state_d = MEASURE;
                MEASURE: if (sat)  state_d = IDLE;
                default:           state_d = IDLE;
            endcase
        end
    end

    // Edge cycle counts as cycle 1 of the new period and as its first high cycle.
    always_comb begin
        cnt_d  = '0;
        hcnt_d = '0;
        accept = 1'b0;
        to_set = 1'b0;
        to_clr = !mif.EN_i;
        if (mif.EN_i) begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        cnt_d  = CNT_ONE;
                        hcnt_d = CNT_ONE;
                    end
                end
                MEASURE: begin
                    if (sat) begin
                        to_set = 1'b1;
                    end else if (rise) begin
                        accept = 1'b1;
                        to_clr = 1'b1;
                        cnt_d  = CNT_ONE;
                        hcnt_d = CNT_ONE;
                    end else begin
                        cnt_d  = cnt_q + CNT_ONE;
                        hcnt_d = hcnt_q + {{(CNT_W-1){1'b0}}, s};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK_i or negedge RSTn_i) begin
        if (!RSTn_i) begin
            cnt_q     <= '0;
            hcnt_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
            valid_q <= accept;
            if (accept) begin
                period_q <= cnt_q;
                high_q   <= hcnt_q;
            end
            if (to_set)      timeout_q <= 1'b1;
            else if (to_clr) timeout_q <= 1'b0;
        end
    end

    assign mif.PERIOD_o  = period_q;
    assign mif.HIGH_o    = high_q;
    assign mif.VALID_o   = valid_q;
    assign mif.TIMEOUT_o = timeout_q;
endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter: a period/duty model over the sampled
// SIG history predicts each measurement; a negedge monitor checks the DUT.
module tb_clk_period_meter;
    localparam int CNT_W = 8;
    localparam int SS    = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    typedef struct {
        int p;
        int h;
    } meas_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    clk_period_meter_if #(.CNT_W(CNT_W)) mif ();

    clk_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SS)) dut (
        .CLK_i  (clk),
        .RSTn_i (rst_n),
        .mif    (mif)
    );

    always #5 clk = ~clk;

    meas_t exp_q[$];
    bit    sigq[$];
    bit    svq[$];
    bit    m_armed = 0;
    bit    m_to = 0;
    int    m_r1 = 0;
    int    m_lastp = 0;
    int    m_lasth = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: SIG as seen SS cycles late; a period is the distance between
    // consecutive accepted rises, high time the number of high samples between them.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                sigq.delete();
                svq.delete();
                m_armed = 0;
                m_to    = 0;
                m_lastp = 0;
                m_lasth = 0;
            end else begin
                int  t;
                bit  sv, pv, rise;
                t    = svq.size();
                sv   = (t >= SS) ? sigq[t-SS] : 1'b0;
                pv   = (t >= 1) ? svq[t-1] : 1'b0;
                rise = sv & ~pv;
                if (!mif.EN_i) begin
                    m_armed = 0;
                    m_to    = 0;
                end else if (m_armed) begin
                    if (t - m_r1 == MAXC) begin
                        m_to    = 1;
                        m_armed = 0;
                    end else if (rise) begin
                        meas_t m;
                        m.p = t - m_r1;
                        m.h = 0;
                        for (int i = m_r1; i < t; i++) m.h += int'(svq[i]);
                        exp_q.push_back(m);
                        m_lastp = m.p;
                        m_lasth = m.h;
                        m_to    = 0;
                        m_r1    = t;
                    end
                end else if (rise) begin
                    m_armed = 1;
                    m_r1    = t;
                end
                sigq.push_back(mif.SIG_i);
                svq.push_back(sv);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                chk("rst_period", int'(mif.PERIOD_o), 0);
                chk("rst_valid", int'(mif.VALID_o), 0);
                chk("rst_timeout", int'(mif.TIMEOUT_o), 0);
            end else begin
                chk("valid", int'(mif.VALID_o), int'(exp_q.size() != 0));
                if (mif.VALID_o && exp_q.size() != 0) begin
                    meas_t m;
                    m = exp_q.pop_front();
                    chk("period", int'(mif.PERIOD_o), m.p);
                    chk("high", int'(mif.HIGH_o), m.h);
                end
                exp_q.delete();
                chk("timeout", int'(mif.TIMEOUT_o), int'(m_to));
                chk("period_hold", int'(mif.PERIOD_o), m_lastp);
                chk("high_hold", int'(mif.HIGH_o), m_lasth);
            end
        end
    end

    task automatic cyc(input bit s, input bit e);
        @(negedge clk);
        mif.SIG_i = s;
        mif.EN_i  = e;
    endtask

    task automatic wave(input int p, input int h, input int n, input bit e);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < p; i++) cyc(i < h, e);
    endtask

    initial begin
        mif.EN_i  = 1'b0;
        mif.SIG_i = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        wave(2, 1, 10, 1);              // divide-by-2
        wave(6, 2, 6, 1);               // divide-by-6, 2 high / 4 low
        cyc(1, 1);                      // single rise, then stuck low -> timeout
        repeat (300) cyc(0, 1);
        wave(4, 2, 6, 1);               // restart clears timeout on first VALID
        wave(254, 1, 3, 1);             // longest measurable period
        wave(255, 1, 3, 1);             // one past: timeout, no VALID
        wave(4, 2, 4, 1);
        cyc(1, 1);
        for (int i = 0; i < 12; i++) cyc((i % 4) >= 1 && (i % 4) < 2, 0);
        wave(4, 2, 5, 1);               // re-arm after enable drop

        wave(4, 2, 4, 1);               // async reset mid-measurement
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_period", int'(mif.PERIOD_o), 0);
        chk("async_rst_high", int'(mif.HIGH_o), 0);
        chk("async_rst_valid", int'(mif.VALID_o), 0);
        chk("async_rst_timeout", int'(mif.TIMEOUT_o), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        wave(2, 1, 8, 1);

        for (int it = 0; it < 40; it++) begin
            int p, h, n;
            bit e;
            p = $urandom_range(2, 30);
            h = $urandom_range(1, p - 1);
            n = $urandom_range(1, 4);
            e = ($urandom_range(0, 7) != 0);
            wave(p, h, n, e);
            if ($urandom_range(0, 9) == 0) repeat ($urandom_range(100, 280)) cyc(0, 1);
        end
        repeat (10) cyc(0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Sits directly downstream of the team's clock dividers.
- Takes a divided or slow clock as a plain data signal (SIG_i) and synchronises it into the CLK_i domain.
- Measures its period and high time in CLK_i cycles, and reports each completed measurement with a one-cycle valid strobe.
- Used on-board to self-check divider ratio and duty; no logic is clocked by SIG_i.

Parameters:
- CNT_W, 16, width of period/high counters and outputs; max measurable period = 2^CNT_W-1 cycles.
- SYNC_STAGES, 2, flip-flop stages in the SIG_i synchroniser (legal 2..4).

Ports:
- CLK_i  input  1  system clock; all logic on posedge.
- RSTn_i  input  1  asynchronous, active-low reset.
- EN_i  input  1  measurement enable (synchronous to CLK_i).
- SIG_i  input  1  signal under measurement (asynchronous, e.g. a divider output).
- PERIOD_o  output  CNT_W  last measured period in CLK_i cycles.
- HIGH_o  output  CNT_W  CLK_i cycles SIG was high within that period.
- VALID_o  output  1  one-cycle pulse when PERIOD_o/HIGH_o update.
- TIMEOUT_o  output  1  sticky flag: no rising edge within the measurable range.

Behaviour:
- Clock and reset: one clock, CLK_i. Reset RSTn_i is asynchronous and active-low.
- Reset values:
  - Synchroniser FFs, edge register, counters and state: 0 / IDLE.
  - PERIOD_o=0, HIGH_o=0, VALID_o=0, TIMEOUT_o=0.
  - Reset mid-measurement aborts it immediately; no VALID_o is issued.
- Synchroniser: SYNC_STAGES FF chain; s = last stage. prev = s delayed one cycle. rise = s & ~prev.
- State machine, two states: IDLE, MEASURE.
- IDLE:
  - cnt and hcnt are held at 0.
  - On EN_i=1 and rise: go to MEASURE, cnt<=1, hcnt<=1.
  - The first edge never produces VALID_o.
- MEASURE, no rise: cnt<=cnt+1; hcnt<=hcnt+s.
- MEASURE, rise with cnt < 2^CNT_W-1:
  - PERIOD_o<=cnt, HIGH_o<=hcnt, VALID_o<=1.
  - TIMEOUT_o<=0.
  - cnt<=1, hcnt<=1; remain in MEASURE.
- MEASURE, cnt == 2^CNT_W-1 (with or without rise):
  - TIMEOUT_o<=1, go to IDLE.
  - PERIOD_o/HIGH_o unchanged; no VALID_o.
- Cycle counting convention:
  - The edge cycle counts as cycle 1 of the new period and as its first high cycle.
  - PERIOD_o = number of CLK_i cycles from one rise to the next.
- Examples:
  - SIG toggling every CLK_i cycle (/2 divider): PERIOD_o=2, HIGH_o=1.
  - /4 with 50% duty: PERIOD_o=4, HIGH_o=2.
- Latency:
  - A SIG_i rising edge sampled at posedge k is seen as rise at posedge k+SYNC_STAGES.
  - VALID_o is asserted in the following cycle.
  - Steady-state measurements are latency-invariant.
- EN_i=0:
  - Forces IDLE on the next edge; counters cleared.
  - PERIOD_o/HIGH_o hold; VALID_o=0.
  - TIMEOUT_o is cleared.
  - Re-enable re-arms: the first edge after re-enable is discarded.
- VALID_o is high for exactly one cycle per accepted edge and never high in two consecutive cycles, because a period is ≥2.
- hcnt cannot exceed cnt, so no separate overflow check is needed.
- Arithmetic: unsigned, CNT_W bits. cnt never wraps because the saturation check precedes increment.
- SIG_i glitches shorter than one CLK_i period may be missed. This is acceptable; no filtering.

Decomposition:
- Shared package: state encoding (IDLE=1'b0, MEASURE=1'b1) and the default CNT_W/SYNC_STAGES constants.
- One natural sub-module: sync_edge_detect (parameter SYNC_STAGES; inputs CLK_i, RSTn_i, D_i; outputs Q_o, RISE_o). It is reusable by other blocks consuming divider outputs.

Test Plan:
- /2 stimulus: SIG_i toggles every CLK_i cycle, EN_i=1. Required: first VALID_o after 2 rises; then VALID_o every 2 cycles; PERIOD_o=2, HIGH_o=1.
- /6 with 2-high/4-low duty. Required: PERIOD_o=6, HIGH_o=2, VALID_o every 6 cycles; the first rise after enable yields no VALID_o.
- CNT_W=8, SIG_i stuck low after one rise. Required: TIMEOUT_o=1 exactly 255 cycles after the rise was detected, state IDLE, PERIOD_o unchanged. Restarting a /4 clock: TIMEOUT_o stays 1 until the first VALID_o (second rise), then 0 with PERIOD_o=4.
- CNT_W=8, period of exactly 254 cycles: VALID_o with PERIOD_o=254. Period of 255: TIMEOUT_o, no VALID_o.
- EN_i dropped mid-period on a /4 clock, then raised. Required: no VALID_o while low; outputs hold 4/2; TIMEOUT_o=0; the first rise after re-enable is discarded, the next gives PERIOD_o=4.
- RSTn_i asserted asynchronously between clock edges mid-MEASURE. Required: all outputs 0 immediately (before the next posedge); after release, behaves as the fresh-start /2 case.
